keyboard_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (LED set, reset, typematic rate, …) from the CPU I/O side to the keyboard over the same kb_clk/kb_data pair the keyboard receiver listens on. Performs request-to-send (clock inhibit, data low), shifts 8 data bits LSB first plus odd parity on device-generated clock falling edges, releases data for the stop bit, and checks the device ACK. Lines are open-drain: the block only ever drives low, via output enables, and samples the pins through synchronizers.

---
 rtl/keyboard_tx.sv | 181 ++++++++++++++++++
 tb/tb_keyboard_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd
// parity, stop, then device ACK check. Open-drain lines driven only via output enables.
module keyboard_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_ctrl_data,
    input  logic       io_ctrl_start,
    output logic       io_ctrl_busy,
    output logic       io_ctrl_done,
    output logic       io_ctrl_error,
    input  logic       io_keyboard_kb_clk,
    input  logic       io_keyboard_kb_data,
    output logic       io_keyboard_kb_clk_oe,
    output logic       io_keyboard_kb_data_oe
);
    localparam int              INH_W    = $clog2(INHIBIT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, START, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [19:0]      to_cnt_q, to_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;

    logic clk_s1, clk_sync, clk_hist;
    logic data_s1, data_sync;
    logic clk_fall;
    logic timed_out;
    logic in_frame;

    // Synchronizers come out of reset at the idle (pulled-up) level so no false edge appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1    <= 1'b1;
            clk_sync  <= 1'b1;
            clk_hist  <= 1'b1;
            data_s1   <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_s1    <= io_keyboard_kb_clk;
            clk_sync  <= clk_s1;
            clk_hist  <= clk_sync;
            data_s1   <= io_keyboard_kb_data;
            data_sync <= data_s1;
        end
    end

    assign clk_fall  = clk_hist & ~clk_sync;
    assign timed_out = (to_cnt_q == TO_LAST);
    assign in_frame  = (state_q == START) || (state_q == SHIFT) ||
                       (state_q == ACK)   || (state_q == WAIT_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                bit_cnt_d = '0;
                if (io_ctrl_start) begin
                    shift_d   = {~^io_ctrl_data, io_ctrl_data};
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                clk_oe_d  = 1'b0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START, SHIFT: begin
                to_cnt_d = to_cnt_q + 20'd1;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Edges 1..9 put out data bits then parity; edge 10 releases for stop.
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        state_d   = SHIFT;
                    end
                end
            end
            ACK: begin
                to_cnt_d = to_cnt_q + 20'd1;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    done_d    = ~data_sync;
                    error_d   = data_sync;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                to_cnt_d = to_cnt_q + 20'd1;
                if (clk_sync && data_sync) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout wins over any edge this cycle. In WAIT_IDLE the frame already
        // reported its result, so only the lines are released there.
        if (in_frame && timed_out) begin
            done_d    = 1'b0;
            error_d   = (state_q != WAIT_IDLE);
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    assign io_ctrl_busy           = busy_q;
    assign io_ctrl_done           = done_q;
    assign io_ctrl_error          = error_q;
    assign io_keyboard_kb_clk_oe  = clk_oe_q;
    assign io_keyboard_kb_data_oe = data_oe_q;
endmodule

// File: tb/tb_keyboard_tx.sv
// Bench for keyboard_tx: device model clocks frames and ACKs; a scoreboard
// checks captured frames and done/error pulses against queued expectations.
module tb_keyboard_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       start = 1'b0;
    logic       busy, done, error, clk_oe, data_oe;
    logic       kb_clk, kb_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    logic [7:0] data_t = '0;
    logic       start_t = 1'b0;
    logic       busy_t, done_t, error_t, clk_oe_t, data_oe_t;
    logic       kb_clk_t, kb_data_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_frame_q[$];
    logic [1:0]  exp_resp_q[$];
    logic [1:0]  exp_resp_t_q[$];

    assign kb_clk    = ~(clk_oe | dev_clk_low);
    assign kb_data   = ~(data_oe | dev_data_low);
    assign kb_clk_t  = ~clk_oe_t;
    assign kb_data_t = ~data_oe_t;

    keyboard_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(20000)) dut (
        .clk(clk), .rst(rst),
        .io_ctrl_data(data), .io_ctrl_start(start),
        .io_ctrl_busy(busy), .io_ctrl_done(done), .io_ctrl_error(error),
        .io_keyboard_kb_clk(kb_clk), .io_keyboard_kb_data(kb_data),
        .io_keyboard_kb_clk_oe(clk_oe), .io_keyboard_kb_data_oe(data_oe)
    );

    keyboard_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200)) dut_t (
        .clk(clk), .rst(rst),
        .io_ctrl_data(data_t), .io_ctrl_start(start_t),
        .io_ctrl_busy(busy_t), .io_ctrl_done(done_t), .io_ctrl_error(error_t),
        .io_keyboard_kb_clk(kb_clk_t), .io_keyboard_kb_data(kb_data_t),
        .io_keyboard_kb_clk_oe(clk_oe_t), .io_keyboard_kb_data_oe(data_oe_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitors: every done/error pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (done || error)) begin
            if (exp_resp_q.size() == 0)
                check("unexpected_pulse", {30'd0, done, error}, 32'd0);
            else
                check("resp", {30'd0, done, error}, {30'd0, exp_resp_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && (done_t || error_t)) begin
            if (exp_resp_t_q.size() == 0)
                check("unexpected_pulse_t", {30'd0, done_t, error_t}, 32'd0);
            else
                check("resp_t", {30'd0, done_t, error_t}, {30'd0, exp_resp_t_q.pop_front()});
        end
    end

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (kb_clk === 1'b1 && kb_data === 1'b0 && clk_oe === 1'b0) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic device_frame(input bit ack, input bit stray);
        logic [10:0] cap;
        bit ok;
        cap = '0;
        wait_rts(ok);
        check("rts_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        repeat (5) tick();
        cap[0] = kb_data;
        for (int n = 1; n <= 10; n++) begin
            dev_clk_low = 1'b1;
            repeat (40) tick();
            cap[n] = kb_data;
            dev_clk_low = 1'b0;
            repeat (40) tick();
            if (stray && n == 3) begin
                start = 1'b1;
                data  = 8'h55;
                tick();
                start = 1'b0;
                data  = 8'h00;
            end
        end
        dev_data_low = ack;
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (40) tick();
        dev_clk_low = 1'b0;
        repeat (5) tick();
        dev_data_low = 1'b0;
        if (exp_frame_q.size() == 0)
            check("frame_unexpected", {21'd0, cap}, 32'd0);
        else
            check("frame", {21'd0, cap}, {21'd0, exp_frame_q.pop_front()});
    endtask

    task automatic send(input logic [7:0] b, input logic par, input bit ack, input bit stray);
        exp_frame_q.push_back({1'b1, par, b, 1'b0});
        exp_resp_q.push_back(ack ? 2'b10 : 2'b01);
        tick();
        start = 1'b1;
        data  = b;
        tick();
        start = 1'b0;
        data  = 8'h00;
        check("busy_on_accept", {31'd0, busy}, 32'd1);
        check("clk_oe_on_accept", {31'd0, clk_oe}, 32'd1);
        repeat (9) tick();
        check("inhibit_lines", {30'd0, clk_oe, data_oe}, 32'd2);
        tick();
        check("req_lines", {30'd0, clk_oe, data_oe}, 32'd3);
        tick();
        check("start_lines", {30'd0, clk_oe, data_oe}, 32'd1);
        device_frame(ack, stray);
        for (int i = 0; i < 100 && busy; i++) tick();
        check("busy_released", {31'd0, busy}, 32'd0);
        check("resp_consumed", exp_resp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        bit found;

        repeat (3) tick();
        check("reset_main", {27'd0, busy, done, error, clk_oe, data_oe}, 32'd0);
        check("reset_t", {27'd0, busy_t, done_t, error_t, clk_oe_t, data_oe_t}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Device traffic while idle must be ignored.
        for (int i = 0; i < 8; i++) begin
            dev_clk_low = ~dev_clk_low;
            repeat (7) tick();
            check("idle_quiet", {29'd0, busy, clk_oe, data_oe}, 32'd0);
        end
        dev_clk_low = 1'b0;
        repeat (10) tick();

        send(8'hED, 1'b1, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'hC3, 1'b1, 1'b1, 1'b1);
        send(8'h55, 1'b1, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b1, 1'b0);

        // Timeout: dut_t's device never clocks; START is entered 12 cycles after accept.
        exp_resp_t_q.push_back(2'b01);
        tick();
        start_t = 1'b1;
        data_t  = 8'hA5;
        tick();
        start_t = 1'b0;
        k = 1;
        found = 1'b0;
        while (k < 400 && !found) begin
            if (error_t) found = 1'b1;
            else begin
                tick();
                k++;
            end
        end
        check("timeout_latency", k, 32'd212);
        check("timeout_lines", {29'd0, busy_t, clk_oe_t, data_oe_t}, 32'd0);
        tick();
        check("timeout_single_pulse", {31'd0, error_t}, 32'd0);
        check("timeout_resp_consumed", exp_resp_t_q.size(), 32'd0);

        // Reset in the middle of the data bits.
        tick();
        start = 1'b1;
        data  = 8'hA5;
        tick();
        start = 1'b0;
        wait_rts(ok);
        check("rts_before_reset", {31'd0, ok}, 32'd1);
        for (int n = 1; n <= 4; n++) begin
            dev_clk_low = 1'b1;
            repeat (40) tick();
            dev_clk_low = 1'b0;
            repeat (40) tick();
        end
        dev_clk_low = 1'b1;
        repeat (5) tick();
        check("mid_shift_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_async", {27'd0, busy, done, error, clk_oe, data_oe}, 32'd0);
        #2 dev_clk_low = 1'b0;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        check("after_reset_idle", {29'd0, busy, clk_oe, data_oe}, 32'd0);
        check("after_reset_no_resp", exp_resp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
